// File: rtl/charge_deposit.sv
`default_nettype none
// ============================================================================
//  Module   : charge_deposit
//  Purpose  : Read-modify-write scatter stage for the quad-banked charge grid.
//             Each accepted particle names a base grid cell (x0,y0) and four
//             bilinear weights. The four neighbouring cells are read on port
//             A, the weights are added, and the sums are written back on
//             port B RD_LAT+1 cycles after the particle is accepted.
//             Intake stalls while any of the four cells still has a write in
//             flight, so no update is ever lost.
//  Ports    : clk, rst          clock, synchronous active-high reset
//             in_valid_i/in_ready_o/in_addr_i/in_w_i/in_last_i
//                               particle intake (valid/ready handshake)
//             mem_addra_o/mem_wea_o/mem_douta_i
//                               port A, read only, data in request order
//             mem_addrb_o/mem_web_o/mem_dinb_o
//                               port B, registered write-back
//             swap_rout_o       constant 1: request-order read return
//             busy_o            particle in flight or batch still open
//             done_o            1-cycle pulse when a batch's last write issues
//             sat_flag_o        sticky saturation flag (CHARGE_SAT_EN only)
//  Config   : CHARGE_SAT_EN defined   -> sums saturate at 2^CWIDTH-1
//             CHARGE_SAT_EN undefined -> sums wrap mod 2^CWIDTH
//  Notes    : ADDRW/XBITS default to the codebase grid size (GRID_ADDRWIDTH,
//             PINT). Point index i = {dy,dx}; lane i of every 4-wide bus
//             sits at bits [i*W +: W].
//  Revision : 1.0  initial release
// ============================================================================
module charge_deposit #(
  parameter int CWIDTH = 24,
  parameter int ADDRW  = 10,
  parameter int XBITS  = 5,
  parameter int RD_LAT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [ADDRW-1:0]    in_addr_i,
  input  logic [4*CWIDTH-1:0] in_w_i,
  input  logic                in_last_i,
  output logic [4*ADDRW-1:0]  mem_addra_o,
  output logic [3:0]          mem_wea_o,
  input  logic [4*CWIDTH-1:0] mem_douta_i,
  output logic [4*ADDRW-1:0]  mem_addrb_o,
  output logic [3:0]          mem_web_o,
  output logic [4*CWIDTH-1:0] mem_dinb_o,
  output logic                swap_rout_o,
  output logic                busy_o,
  output logic                done_o
`ifdef CHARGE_SAT_EN
  ,
  output logic                sat_flag_o
`endif
);

  localparam int YBITS = ADDRW - XBITS;
  localparam logic [XBITS-1:0] X_ONE = XBITS'(1);
  localparam logic [YBITS-1:0] Y_ONE = YBITS'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t state_q, state_d;

  // --------------------------------------------------------------------------
  // Neighbour addressing: the grid is a torus, so the +1 in each field simply
  // overflows inside its own field width.
  // --------------------------------------------------------------------------
  logic [XBITS-1:0]   x0, x1;
  logic [YBITS-1:0]   y0, y1;
  logic [4*ADDRW-1:0] pts;

  assign x0  = in_addr_i[XBITS-1:0];
  assign y0  = in_addr_i[ADDRW-1:XBITS];
  assign x1  = x0 + X_ONE;
  assign y1  = y0 + Y_ONE;
  assign pts = {y1, x1, y1, x0, y0, x1, y0, x0};

  // --------------------------------------------------------------------------
  // Read pipeline: one stage per cycle of memory read latency. Stage RD_LAT-1
  // lines up with the cycle in which mem_douta_i carries that entry's data.
  // --------------------------------------------------------------------------
  logic [RD_LAT-1:0]   pv_q;
  logic [RD_LAT-1:0]   pl_q;
  logic [4*ADDRW-1:0]  pa_q [RD_LAT];
  logic [4*CWIDTH-1:0] pw_q [RD_LAT];

  // Write-back register (the final pipeline stage)
  logic [3:0]          web_q;
  logic [4*ADDRW-1:0]  addrb_q;
  logic [4*CWIDTH-1:0] dinb_q;
  logic [4*CWIDTH-1:0] dinb_d;
  logic                wr_last_q;

  logic hazard;
  logic accept;

  // --------------------------------------------------------------------------
  // Read-after-write hazard: every in-flight entry, including the one whose
  // write is on port B this very cycle, blocks a new read of the same cells.
  // A same-cycle read would otherwise return the pre-write value.
  // --------------------------------------------------------------------------
  always_comb begin
    hazard = 1'b0;
    for (int s = 0; s < RD_LAT; s++) begin
      if (pv_q[s]) begin
        for (int i = 0; i < 4; i++) begin
          for (int j = 0; j < 4; j++) begin
            if (pts[i*ADDRW +: ADDRW] == pa_q[s][j*ADDRW +: ADDRW]) begin
              hazard = 1'b1;
            end
          end
        end
      end
    end
    if (web_q[0]) begin
      for (int i = 0; i < 4; i++) begin
        for (int j = 0; j < 4; j++) begin
          if (pts[i*ADDRW +: ADDRW] == addrb_q[j*ADDRW +: ADDRW]) begin
            hazard = 1'b1;
          end
        end
      end
    end
  end

  assign in_ready_o = !rst && (state_q != S_DRAIN) && !hazard;
  assign accept     = in_valid_i && in_ready_o;

  // --------------------------------------------------------------------------
  // Batch FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = in_last_i ? S_DRAIN : S_RUN;
        end
      end
      S_RUN: begin
        if (accept && in_last_i) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (done_o) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Pipeline shift: control bits are reset so that in-flight entries vanish,
  // payload is free-running and only meaningful alongside a valid bit.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      pv_q <= '0;
      pl_q <= '0;
    end else begin
      pv_q[0] <= accept;
      pl_q[0] <= in_last_i;
      for (int s = 1; s < RD_LAT; s++) begin
        pv_q[s] <= pv_q[s-1];
        pl_q[s] <= pl_q[s-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    pa_q[0] <= pts;
    pw_q[0] <= in_w_i;
    for (int s = 1; s < RD_LAT; s++) begin
      pa_q[s] <= pa_q[s-1];
      pw_q[s] <= pw_q[s-1];
    end
  end

  // --------------------------------------------------------------------------
  // Accumulate: read data plus weight, per point.
  // --------------------------------------------------------------------------
`ifdef CHARGE_SAT_EN
  logic [CWIDTH:0] wide;
  logic            sat_hit;
  logic            sat_q;

  always_comb begin
    dinb_d  = '0;
    wide    = '0;
    sat_hit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wide = {1'b0, mem_douta_i[i*CWIDTH +: CWIDTH]}
           + {1'b0, pw_q[RD_LAT-1][i*CWIDTH +: CWIDTH]};
      if (wide[CWIDTH]) begin
        dinb_d[i*CWIDTH +: CWIDTH] = '1;
        sat_hit                    = 1'b1;
      end else begin
        dinb_d[i*CWIDTH +: CWIDTH] = wide[CWIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sat_q <= 1'b0;
    end else if (pv_q[RD_LAT-1] && sat_hit) begin
      sat_q <= 1'b1;
    end
  end

  assign sat_flag_o = sat_q;
`else
  always_comb begin
    dinb_d = '0;
    for (int i = 0; i < 4; i++) begin
      dinb_d[i*CWIDTH +: CWIDTH] = mem_douta_i[i*CWIDTH +: CWIDTH]
                                 + pw_q[RD_LAT-1][i*CWIDTH +: CWIDTH];
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Write-back register: bubbles drop the enables but keep address/data.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      web_q     <= 4'b0000;
      addrb_q   <= '0;
      dinb_q    <= '0;
      wr_last_q <= 1'b0;
    end else if (pv_q[RD_LAT-1]) begin
      web_q     <= 4'b1111;
      addrb_q   <= pa_q[RD_LAT-1];
      dinb_q    <= dinb_d;
      wr_last_q <= pl_q[RD_LAT-1];
    end else begin
      web_q     <= 4'b0000;
      wr_last_q <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign mem_addra_o = rst ? '0 : pts;
  assign mem_wea_o   = 4'b0000;
  assign swap_rout_o = 1'b1;
  assign mem_addrb_o = addrb_q;
  assign mem_web_o   = web_q;
  assign mem_dinb_o  = dinb_q;
  assign done_o      = web_q[0] & wr_last_q;
  assign busy_o      = (|pv_q) | web_q[0] | (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_charge_deposit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_charge_deposit
//  Purpose  : Self-checking bench for charge_deposit on a 16x8 torus grid.
//             The bench owns the grid memory (read latency RD_LAT, read-first)
//             and a reference model: a golden grid updated with plain
//             arithmetic at accept time, plus a queue of expected writes.
//  Revision : 1.0  initial release
// ============================================================================
module tb_charge_deposit;

  localparam int CW = 24;
  localparam int AW = 7;
  localparam int XB = 4;
  localparam int RL = 4;
  localparam int NX = 16;
  localparam int NY = 8;
  localparam int NC = 128;
  localparam longint MAXV = (longint'(1) << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_addr;
  logic [4*CW-1:0] in_w;
  logic          in_last;
  logic [4*AW-1:0] mem_addra;
  logic [3:0]    mem_wea;
  logic [4*CW-1:0] mem_douta;
  logic [4*AW-1:0] mem_addrb;
  logic [3:0]    mem_web;
  logic [4*CW-1:0] mem_dinb;
  logic          swap_rout;
  logic          busy;
  logic          done;
`ifdef CHARGE_SAT_EN
  logic          sat_flag;
`endif

  always #5 clk = ~clk;

  charge_deposit #(.CWIDTH(CW), .ADDRW(AW), .XBITS(XB), .RD_LAT(RL)) dut (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_addr_i(in_addr),
    .in_w_i(in_w), .in_last_i(in_last),
    .mem_addra_o(mem_addra), .mem_wea_o(mem_wea), .mem_douta_i(mem_douta),
    .mem_addrb_o(mem_addrb), .mem_web_o(mem_web), .mem_dinb_o(mem_dinb),
    .swap_rout_o(swap_rout), .busy_o(busy), .done_o(done)
`ifdef CHARGE_SAT_EN
    , .sat_flag_o(sat_flag)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // ---------------- environment memory and reference model ----------------
  logic [CW-1:0]   cells [NC];
  logic [CW-1:0]   gold  [NC];
  logic [4*CW-1:0] rdbuf [8];

  typedef struct {
    int              due;
    logic [4*AW-1:0] pts;
    logic [4*CW-1:0] nv;
    logic [4*CW-1:0] ov;
    logic            last;
    logic            sat;
  } rec_t;

  rec_t q[$];
  int   cyc = 0;
  logic run_m = 1'b0;
  logic sat_m = 1'b0;

  int   web_cnt, done_cnt, web_first, web_last;
  logic cap_seen, cap_done, last_ready;
  int   cap_cyc;
  logic [4*AW-1:0] cap_a;
  logic [4*CW-1:0] cap_d;

  function automatic logic [4*AW-1:0] a4(input int p0, input int p1, input int p2, input int p3);
    logic [AW-1:0] b0, b1, b2, b3;
    b0 = AW'(p0); b1 = AW'(p1); b2 = AW'(p2); b3 = AW'(p3);
    return {b3, b2, b1, b0};
  endfunction

  function automatic logic [4*CW-1:0] w4(input logic [CW-1:0] p0, input logic [CW-1:0] p1,
                                         input logic [CW-1:0] p2, input logic [CW-1:0] p3);
    return {p3, p2, p1, p0};
  endfunction

  // Torus neighbours from plain x/y arithmetic
  function automatic logic [4*AW-1:0] neigh(input int a);
    int x, y, xp, yp;
    x  = a % NX;
    y  = a / NX;
    xp = (x + 1) % NX;
    yp = (y + 1) % NY;
    return a4(y*NX + x, y*NX + xp, yp*NX + x, yp*NX + xp);
  endfunction

  function automatic logic overlap(input logic [4*AW-1:0] p, input logic [4*AW-1:0] e);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (p[i*AW +: AW] == e[j*AW +: AW]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_accept(input logic [AW-1:0] a, input logic [4*CW-1:0] w, input logic l);
    rec_t   r;
    int     p;
    longint s;
    r.due  = cyc + RL + 1;
    r.pts  = neigh(int'(a));
    r.last = l;
    r.sat  = 1'b0;
    r.nv   = '0;
    r.ov   = '0;
    for (int i = 0; i < 4; i++) begin
      p = int'(r.pts[i*AW +: AW]);
      r.ov[i*CW +: CW] = gold[p];
      s = longint'(gold[p]) + longint'(w[i*CW +: CW]);
      if (s > MAXV) begin
`ifdef CHARGE_SAT_EN
        s = MAXV;
        r.sat = 1'b1;
`else
        s = s - (MAXV + 1);
`endif
      end
      gold[p] = s[CW-1:0];
      r.nv[i*CW +: CW] = s[CW-1:0];
    end
    q.push_back(r);
    run_m = !l;
  endtask

  // One clock cycle: entered at the falling edge of cycle cyc.
  task automatic cyc_step(input logic v, input logic [AW-1:0] a, input logic [4*CW-1:0] w,
                          input logic l, input logic r, output logic acc);
    logic has, er, drain, ovl;
    has = (q.size() > 0) && (q[0].due == cyc);
    if (has) begin
      if (q[0].sat) sat_m = 1'b1;
      chk("web", mem_web, 4'hF);
      chk("addrb", mem_addrb, q[0].pts);
      chk("dinb", mem_dinb, q[0].nv);
      chk("done", done, q[0].last);
    end else begin
      chk("web_idle", mem_web, 4'h0);
      chk("done_idle", done, 1'b0);
    end
    chk("busy", busy, (q.size() > 0) || run_m);
`ifdef CHARGE_SAT_EN
    chk("sat_flag", sat_flag, sat_m);
`endif
    if (mem_web != 4'h0) begin
      web_cnt++;
      if (web_cnt == 1) web_first = cyc;
      web_last = cyc;
      cap_seen = 1'b1; cap_cyc = cyc; cap_a = mem_addrb; cap_d = mem_dinb; cap_done = done;
    end
    if (done) done_cnt++;

    rst = r; in_valid = v; in_addr = a; in_w = w; in_last = l;
    mem_douta = rdbuf[(cyc + 8 - RL) % 8];
    #1;
    drain = 1'b0; ovl = 1'b0;
    foreach (q[k]) begin
      if (q[k].last) drain = 1'b1;
      if (overlap(neigh(int'(a)), q[k].pts)) ovl = 1'b1;
    end
    er = !r && !drain && !ovl;
    chk("in_ready", in_ready, er);
    last_ready = in_ready;
    for (int i = 0; i < 4; i++) rdbuf[cyc % 8][i*CW +: CW] = cells[mem_addra[i*AW +: AW]];
    for (int i = 0; i < 4; i++) if (mem_web[i]) cells[mem_addrb[i*AW +: AW]] = mem_dinb[i*CW +: CW];
    acc = v && in_ready && !r;

    while (q.size() > 0 && q[0].due <= cyc) void'(q.pop_front());
    if (r) begin
      for (int k = q.size() - 1; k >= 0; k--)
        for (int i = 0; i < 4; i++) gold[q[k].pts[i*AW +: AW]] = q[k].ov[i*CW +: CW];
      q.delete();
      run_m = 1'b0;
      sat_m = 1'b0;
    end else if (acc) begin
      model_accept(a, w, l);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int k = 0; k < n; k++) cyc_step(1'b0, '0, '0, 1'b0, 1'b0, acc);
  endtask

  task automatic send(input logic [AW-1:0] a, input logic [4*CW-1:0] w, input logic l, output int t);
    logic acc;
    acc = 1'b0;
    t = -1;
    for (int k = 0; k < 50 && !acc; k++) begin
      t = cyc;
      cyc_step(1'b1, a, w, l, 1'b0, acc);
    end
    if (!acc) chk("send_timeout", 1'b0, 1'b1);
  endtask

  task automatic drain_all();
    for (int k = 0; k < 60 && q.size() > 0; k++) idle(1);
    if (q.size() != 0) chk("drain_timeout", 1'b0, 1'b1);
  endtask

  task automatic clear_grid();
    drain_all();
    for (int c = 0; c < NC; c++) begin cells[c] = '0; gold[c] = '0; end
  endtask

  typedef struct {
    logic [AW-1:0]   addr;
    logic [4*CW-1:0] w;
    logic [CW-1:0]   pre;
    logic [4*AW-1:0] ea;
    logic [4*CW-1:0] ed;
  } tv_t;

  tv_t tv [5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc, hold, v, r, hl;
    logic [AW-1:0] ha;
    logic [4*CW-1:0] hw;
    int t, t0, t1, t2;

    tv[0] = '{addr: 7'd0,  w: w4(1, 2, 3, 4),     pre: 24'd0, ea: a4(0, 1, 16, 17),
              ed: w4(1, 2, 3, 4)};
    tv[1] = '{addr: 7'd127, w: w4(10, 20, 30, 40), pre: 24'd0, ea: a4(127, 112, 15, 0),
              ed: w4(10, 20, 30, 40)};
    tv[2] = '{addr: 7'd63, w: w4(7, 7, 7, 7),     pre: 24'd100, ea: a4(63, 48, 79, 64),
              ed: w4(107, 107, 107, 107)};
    tv[3] = '{addr: 7'd18, w: w4(0, 0, 0, 0),     pre: 24'd5, ea: a4(18, 19, 34, 35),
              ed: w4(5, 5, 5, 5)};
`ifdef CHARGE_SAT_EN
    tv[4] = '{addr: 7'd34, w: w4(5, 1, 2, 0), pre: 24'hFFFFFE, ea: a4(34, 35, 50, 51),
              ed: w4(24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFE)};
`else
    tv[4] = '{addr: 7'd34, w: w4(5, 1, 2, 0), pre: 24'hFFFFFE, ea: a4(34, 35, 50, 51),
              ed: w4(24'd3, 24'hFFFFFF, 24'd0, 24'hFFFFFE)};
`endif

    for (int c = 0; c < NC; c++) begin cells[c] = '0; gold[c] = '0; end
    for (int k = 0; k < 8; k++) rdbuf[k] = '0;
    web_cnt = 0; done_cnt = 0; web_first = 0; web_last = 0;
    cap_seen = 1'b0; cap_done = 1'b0; cap_cyc = 0; cap_a = '0; cap_d = '0; last_ready = 1'b0;
    rst = 1'b1; in_valid = 1'b0; in_addr = 7'd9; in_w = '0; in_last = 1'b0; mem_douta = '0;

    // ---------------- reset state ----------------
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", in_ready, 1'b0);
    chk("rst_web", mem_web, 4'h0);
    chk("rst_addra", mem_addra, '0);
    chk("rst_addrb", mem_addrb, '0);
    chk("rst_dinb", mem_dinb, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("wea_tied", mem_wea, 4'h0);
    chk("swap_tied", swap_rout, 1'b1);
    cyc_step(1'b0, '0, '0, 1'b0, 1'b1, acc);

    // ---------------- table: single particles ----------------
    for (int n = 0; n < 5; n++) begin
      clear_grid();
      for (int i = 0; i < 4; i++) begin
        cells[tv[n].ea[i*AW +: AW]] = tv[n].pre;
        gold[tv[n].ea[i*AW +: AW]]  = tv[n].pre;
      end
      cap_seen = 1'b0;
      send(tv[n].addr, tv[n].w, 1'b1, t);
      for (int k = 0; k < 10 && !cap_seen; k++) idle(1);
      chk("tv_seen", cap_seen, 1'b1);
      chk("tv_latency", cap_cyc - t, RL + 1);
      chk("tv_addrb", cap_a, tv[n].ea);
      chk("tv_dinb", cap_d, tv[n].ed);
      chk("tv_done", cap_done, 1'b1);
      chk("tv_busy_fall", busy, 1'b0);
    end
`ifdef CHARGE_SAT_EN
    chk("tv_sat_flag", sat_flag, 1'b1);
`endif

    // ---------------- back-to-back, no overlap ----------------
    clear_grid();
    web_cnt = 0;
    send(7'd0, w4(1, 1, 1, 1), 1'b0, t0);
    for (int k = 1; k < 4; k++) begin
      send(AW'(4*k), w4(k+1, k+1, k+1, k+1), k == 3, t);
      chk("b2b_no_stall", t - t0, k);
    end
    idle(10);
    chk("b2b_writes", web_cnt, 4);
    chk("b2b_consecutive", web_last - web_first, 3);

    // ---------------- same cell twice ----------------
    clear_grid();
    send(7'd5, w4(1, 1, 1, 1), 1'b0, t1);
    send(7'd5, w4(1, 1, 1, 1), 1'b1, t2);
    chk("raw_stalled", (t2 - t1) >= RL + 1, 1'b1);
    drain_all();
    idle(1);
    chk("raw_cell5", cells[5], 24'd2);
    chk("raw_cell22", cells[22], 24'd2);

    // ---------------- reset with three in flight ----------------
    clear_grid();
    send(7'd0, w4(3, 3, 3, 3), 1'b0, t);
    send(7'd4, w4(3, 3, 3, 3), 1'b0, t);
    send(7'd8, w4(3, 3, 3, 3), 1'b0, t);
    cyc_step(1'b0, '0, '0, 1'b0, 1'b1, acc);
    web_cnt = 0; done_cnt = 0;
    idle(1);
    chk("post_rst_ready", last_ready, 1'b1);
    idle(10);
    chk("post_rst_no_write", web_cnt, 0);
    chk("post_rst_no_done", done_cnt, 0);
    chk("post_rst_cell0", cells[0], 24'd0);

    // ---------------- randomized traffic ----------------
    clear_grid();
    hold = 1'b0; ha = '0; hw = '0; hl = 1'b0;
    for (int k = 0; k < 800; k++) begin
      if (!hold) begin
        ha = ($urandom_range(0, 4) == 0) ? AW'($urandom_range(0, NC-1)) : AW'($urandom_range(0, 31));
        for (int i = 0; i < 4; i++)
          hw[i*CW +: CW] = ($urandom_range(0, 19) == 0) ? CW'($urandom_range(0, 32'hFFFFFF))
                                                          : CW'($urandom_range(0, 1000));
        hl = ($urandom_range(0, 19) == 0);
      end
      v = hold ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 9) < 7);
      r = ($urandom_range(0, 199) == 0);
      cyc_step(v, ha, hw, hl, r, acc);
      hold = v && !acc && !r;
    end
    drain_all();
    idle(2);
    for (int c = 0; c < NC; c++) chk("final_cell", cells[c], gold[c]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
